// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary payload types and the skid-buffer state encoding.
package pipe_pkg;

  localparam int XLEN = 64;
  localparam int XMSB = XLEN - 1;

  typedef struct packed {
    logic [XMSB:0] pc;
    logic [4:0]    rd;
    logic [63:0]   data;
  } ma_wb_t;

  typedef struct packed {
    logic [XMSB:0] pc;
    logic [4:0]    rd;
    logic [XMSB:0] alu;
    logic [XMSB:0] store_data;
    logic [3:0]    mem_op;
  } ex_ma_t;

  localparam int MA_WB_W = $bits(ma_wb_t);
  localparam int EX_MA_W = $bits(ex_ma_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload entry with valid bit; async clear, load enable, payload zeroed when loaded invalid.
module pipe_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage: single register (DEPTH=1) or 2-entry skid buffer (DEPTH=2).
// Skid FSM states: ST_EMPTY = no entries | ST_ONE = head only | ST_FULL = head + skid (in_ready low).
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DW    = MA_WB_W,
  parameter int DEPTH = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          kill,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count
);

  logic          w_accept;
  logic          w_pop;
  logic          w_store;
  logic [DW-1:0] w_head_data;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;
  assign w_store  = w_accept & ~kill & ~flush;
  assign out_data = out_valid ? w_head_data : '0;

  if (DEPTH == 1) begin : g_reg
    logic          w_hv;
    logic [DW-1:0] w_hd;

    assign in_ready = ~w_hv | out_ready;

    pipe_slot #(.DW(DW)) u_head (
      .clk     (clk),
      .rst     (rst),
      .i_load  (flush | w_pop | w_accept),
      .i_valid (w_store),
      .i_data  (in_data),
      .o_valid (w_hv),
      .o_data  (w_hd)
    );

    assign out_valid   = w_hv;
    assign w_head_data = w_hd;
    assign count       = CW'(w_hv);
  end else if (DEPTH == 2) begin : g_skid
    skid_state_t   r_state;
    skid_state_t   w_state_nxt;
    logic          r_in_ready;
    logic          w_head_load, w_head_vin, w_skid_load, w_skid_vin;
    logic [DW-1:0] w_head_din;
    logic          w_hv, w_sv;
    logic [DW-1:0] w_hd, w_sd;

    // in_ready is a flop of the next state, so it never depends on out_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_state_nxt;
        r_in_ready <= (w_state_nxt != ST_FULL);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_head_load = 1'b0;
      w_head_vin  = 1'b0;
      w_head_din  = in_data;
      w_skid_load = 1'b0;
      w_skid_vin  = 1'b0;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
        w_head_load = 1'b1;
        w_skid_load = 1'b1;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_store) begin
              w_head_load = 1'b1;
              w_head_vin  = 1'b1;
              w_state_nxt = ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_store && !w_pop) begin
              w_skid_load = 1'b1;
              w_skid_vin  = 1'b1;
              w_state_nxt = ST_FULL;
            end else if (w_store && w_pop) begin
              w_head_load = 1'b1;
              w_head_vin  = 1'b1;
            end else if (w_pop) begin
              w_head_load = 1'b1;
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (w_pop) begin
              w_head_load = 1'b1;
              w_head_vin  = 1'b1;
              w_head_din  = w_sd;
              w_skid_load = 1'b1;
              w_state_nxt = ST_ONE;
            end
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end
    end

    pipe_slot #(.DW(DW)) u_head (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_head_load),
      .i_valid (w_head_vin),
      .i_data  (w_head_din),
      .o_valid (w_hv),
      .o_data  (w_hd)
    );

    pipe_slot #(.DW(DW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_valid (w_skid_vin),
      .i_data  (in_data),
      .o_valid (w_sv),
      .o_data  (w_sd)
    );

    assign in_ready    = r_in_ready;
    assign out_valid   = w_hv;
    assign w_head_data = w_hd;
    assign count       = CW'(w_hv) + CW'(w_sv);
  end else begin : g_bad_depth
    $error("pipe_stage_elastic: DEPTH must be 1 or 2");
  end

endmodule
